// File: rtl/axis_lpf_shifted_mc.sv
// axis_lpf_shifted_mc
// Multi-channel, time-multiplexed single-pole IIR low-pass filter on AXI-Stream:
//   y[n] = y[n-1] + (x[n] - y[n-1]) >>> alpha
// Each channel (selected by s_axis_tuser) keeps its own state and uses its own shift.
// Optional feature macro: AXIS_LPF_HPF_OUT_EN adds a saturated high-pass output
// (x - y_new) registered alongside the low-pass output.
module axis_lpf_shifted_mc #(
  parameter int n_channels             = 4,
  parameter int ch_width               = 2,
  parameter int inout_width            = 12,
  parameter int inout_decimal_width    = 11,
  parameter int internal_width         = 32,
  parameter int internal_decimal_width = 31
) (
  input  logic                      aclk,
  input  logic                      resetn,
  input  logic [5*n_channels-1:0]   i_alpha,
  input  logic                      i_clear,
  input  logic [inout_width-1:0]    s_axis_tdata,
  input  logic [ch_width-1:0]       s_axis_tuser,
  input  logic                      s_axis_tlast,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [inout_width-1:0]    m_axis_tdata,
  output logic [ch_width-1:0]       m_axis_tuser,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
`ifdef AXIS_LPF_HPF_OUT_EN
  ,
  output logic [inout_width-1:0]    m_axis_tdata_hp
`endif
);

  localparam int SHIFT = internal_decimal_width - inout_decimal_width;
  localparam int DW    = internal_width + 1;

  logic                             r_mValid;
  logic [inout_width-1:0]           r_mData;
  logic [ch_width-1:0]              r_mUser;
  logic                             r_mLast;
  logic signed [internal_width-1:0] r_state [n_channels];

  logic                             w_accept;
  logic                             w_inRange;
  logic [4:0]                       w_alpha;
  logic signed [internal_width-1:0] w_yOld;
  logic signed [DW-1:0]             w_xi;
  logic signed [DW-1:0]             w_diff;
  logic signed [DW-1:0]             w_step;
  logic signed [DW-1:0]             w_sum;
  logic signed [internal_width-1:0] w_yNew;
  logic [inout_width-1:0]           w_lpOut;

  // Single output register without skid: accept whenever the register is free or draining.
  assign s_axis_tready = ~r_mValid | m_axis_tready;
  assign w_accept      = s_axis_tvalid & s_axis_tready;

  // Select the addressed channel's shift and current state; out-of-range indices select nothing.
  always_comb begin
    w_alpha   = '0;
    w_yOld    = '0;
    w_inRange = 1'b0;
    for (int k = 0; k < n_channels; k++) begin
      if (int'(s_axis_tuser) == k) begin
        w_alpha   = i_alpha[5*k +: 5];
        w_yOld    = r_state[k];
        w_inRange = 1'b1;
      end
    end
  end

  // The difference carries one extra bit so it cannot overflow; the new state is a
  // convex combination of inputs and therefore always fits back into internal_width.
  assign w_xi    = DW'(signed'(s_axis_tdata)) <<< SHIFT;
  assign w_diff  = w_xi - DW'(w_yOld);
  assign w_step  = w_diff >>> w_alpha;
  assign w_sum   = DW'(w_yOld) + w_step;
  assign w_yNew  = internal_width'(w_sum);
  assign w_lpOut = w_inRange ? w_yNew[SHIFT +: inout_width] : '0;

  // Per-channel state: clear wins over the write of an accepted sample.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < n_channels; k++) r_state[k] <= '0;
    end else if (i_clear) begin
      for (int k = 0; k < n_channels; k++) r_state[k] <= '0;
    end else if (w_accept && w_inRange) begin
      for (int k = 0; k < n_channels; k++) begin
        if (int'(s_axis_tuser) == k) r_state[k] <= w_yNew;
      end
    end
  end

  // Output register: load on accept, hold until the consumer takes it.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_mValid <= 1'b0;
      r_mData  <= '0;
      r_mUser  <= '0;
      r_mLast  <= 1'b0;
    end else if (w_accept) begin
      r_mValid <= 1'b1;
      r_mData  <= w_lpOut;
      r_mUser  <= s_axis_tuser;
      r_mLast  <= s_axis_tlast;
    end else if (m_axis_tready) begin
      r_mValid <= 1'b0;
    end
  end

  assign m_axis_tvalid = r_mValid;
  assign m_axis_tdata  = r_mData;
  assign m_axis_tuser  = r_mUser;
  assign m_axis_tlast  = r_mLast;

`ifdef AXIS_LPF_HPF_OUT_EN
  localparam logic signed [DW-1:0] HP_MAX = DW'((1 << (inout_width - 1)) - 1);
  localparam logic signed [DW-1:0] HP_MIN = -DW'(1 << (inout_width - 1));

  logic signed [DW-1:0]   w_hpDiff;
  logic signed [DW-1:0]   w_hpShift;
  logic [inout_width-1:0] w_hpSat;
  logic [inout_width-1:0] r_hpData;

  assign w_hpDiff  = w_xi - DW'(w_yNew);
  assign w_hpShift = w_hpDiff >>> SHIFT;

  // Clamp the high-pass residue into the signed output range.
  always_comb begin
    w_hpSat = inout_width'(w_hpShift);
    if (w_hpShift > HP_MAX)      w_hpSat = inout_width'(HP_MAX);
    else if (w_hpShift < HP_MIN) w_hpSat = inout_width'(HP_MIN);
    if (!w_inRange)              w_hpSat = '0;
  end

  // High-pass output register loads together with the low-pass output.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn)       r_hpData <= '0;
    else if (w_accept) r_hpData <= w_hpSat;
  end

  assign m_axis_tdata_hp = r_hpData;
`endif

endmodule

// File: tb/tb_axis_lpf_shifted_mc.sv
// tb_axis_lpf_shifted_mc
// Directed bench for axis_lpf_shifted_mc with a queue scoreboard fed by a
// floor-arithmetic reference model of the filter equation.
module tb_axis_lpf_shifted_mc;

  localparam int SHIFT = 20;

  logic        aclk = 1'b0;
  logic        resetn;
  logic [19:0] i_alpha;
  logic        i_clear;
  logic [11:0] sData;
  logic [1:0]  sUser;
  logic        sLast;
  logic        sValid;
  logic        sReady;
  logic [11:0] mData;
  logic [1:0]  mUser;
  logic        mLast;
  logic        mValid;
  logic        mReady;

  typedef struct {
    logic [11:0] d;
    logic [1:0]  u;
    logic        l;
  } exp_t;

  exp_t        sbQ[$];
  longint      yModel[4];
  int          nTests = 0;
  int          nFail  = 0;
  logic [11:0] lastOut[4];
  logic [1:0]  lastUser;
  logic        haveCh0;
  logic [11:0] prevCh0;
  logic [11:0] firstCh0;
  int          monoErr;
  int          otherNonZero;

  axis_lpf_shifted_mc dut (
    .aclk          (aclk),
    .resetn        (resetn),
    .i_alpha       (i_alpha),
    .i_clear       (i_clear),
    .s_axis_tdata  (sData),
    .s_axis_tuser  (sUser),
    .s_axis_tlast  (sLast),
    .s_axis_tvalid (sValid),
    .s_axis_tready (sReady),
    .m_axis_tdata  (mData),
    .m_axis_tuser  (mUser),
    .m_axis_tlast  (mLast),
    .m_axis_tvalid (mValid),
    .m_axis_tready (mReady)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor at the falling edge: the values seen here are what the next rising edge uses.
  always @(negedge aclk) begin
    if (!resetn) begin
      sbQ.delete();
      for (int k = 0; k < 4; k++) yModel[k] = 0;
    end else begin
      if (mValid && mReady) begin
        nTests++;
        assert (sbQ.size() != 0) else begin
          nFail++;
          $error("[TB] FAIL sbUnderflow observed=output expected=none");
        end
        if (sbQ.size() != 0) begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("sbData", 32'(mData), 32'(e.d));
          checkOutput("sbUser", 32'(mUser), 32'(e.u));
          checkOutput("sbLast", 32'(mLast), 32'(e.l));
          lastOut[mUser] = mData;
          lastUser = mUser;
          if (mUser == 2'd0) begin
            if (!haveCh0) firstCh0 = mData;
            else if ($signed(mData) < $signed(prevCh0)) monoErr++;
            prevCh0 = mData;
            haveCh0 = 1'b1;
          end else if (mData != 12'd0) begin
            otherNonZero++;
          end
        end
      end
      if (sValid && sReady) begin
        exp_t   e;
        longint xi;
        longint yn;
        int     ch;
        int     a;
        ch = int'(sUser);
        a  = int'(i_alpha[5*ch +: 5]);
        xi = longint'($signed(sData)) * (longint'(1) << SHIFT);
        yn = yModel[ch] + ((xi - yModel[ch]) >>> a);
        yModel[ch] = yn;
        e.d = 12'(yn >>> SHIFT);
        e.u = sUser;
        e.l = sLast;
        sbQ.push_back(e);
      end
      if (i_clear) begin
        for (int k = 0; k < 4; k++) yModel[k] = 0;
      end
    end
  end

  task automatic applyStimulus(input int ch, input int x, input logic last, input logic clr);
    bit got;
    @(posedge aclk); #1;
    sValid  = 1'b1;
    sUser   = 2'(ch);
    sData   = 12'(x);
    sLast   = last;
    i_clear = clr;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge aclk);
      if (sReady) got = 1'b1;
    end
    nTests++;
    assert (got) else begin
      nFail++;
      $error("[TB] FAIL acceptTimeout observed=0 expected=1");
    end
  endtask

  task automatic idle();
    @(posedge aclk); #1;
    sValid  = 1'b0;
    i_clear = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (3) @(negedge aclk);
  endtask

  initial begin
    resetn  = 1'b1;
    i_alpha = {5'd8, 5'd8, 5'd0, 5'd8};
    i_clear = 1'b0;
    sData   = '0;
    sUser   = '0;
    sLast   = 1'b0;
    sValid  = 1'b0;
    mReady  = 1'b1;
    haveCh0 = 1'b0;
    prevCh0 = '0;
    firstCh0 = '0;
    monoErr = 0;
    otherNonZero = 0;
    lastUser = '0;
    for (int k = 0; k < 4; k++) lastOut[k] = '0;
    #1 resetn = 1'b0;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("rstValid", 32'(mValid), 32'(0));
    checkOutput("rstData", 32'(mData), 32'(0));
    resetn = 1'b1;
    #1;
    checkOutput("rstReady", 32'(sReady), 32'(1));

    // Test 1: ch0 step response, alpha=8
    applyStimulus(0, 300, 1'b0, 1'b0);
    drain();
    checkOutput("t1First", 32'(lastOut[0]), 32'(12'd1));
    for (int i = 0; i < 2000; i++) applyStimulus(0, 300, 1'b0, 1'b0);
    drain();
    checkOutput("t1Settle", 32'(lastOut[0]), 32'(12'd299));
    for (int i = 0; i < 50; i++) applyStimulus(0, 300, 1'b0, 1'b0);
    drain();
    checkOutput("t1Stay", 32'(lastOut[0]), 32'(12'd299));
    checkOutput("t1Mono", 32'(monoErr), 32'(0));

    // Test 2: alpha=0 on ch1 passes the input straight through
    applyStimulus(1, -512, 1'b1, 1'b0);
    drain();
    checkOutput("t2Data", 32'(lastOut[1]), 32'(12'hE00));
    checkOutput("t2User", 32'(lastUser), 32'(1));

    // Test 3: round-robin over all channels after a clear
    i_alpha = {5'd8, 5'd8, 5'd8, 5'd8};
    @(posedge aclk); #1 i_clear = 1'b1;
    @(posedge aclk); #1 i_clear = 1'b0;
    haveCh0 = 1'b0;
    monoErr = 0;
    otherNonZero = 0;
    for (int i = 0; i < 1800; i++) begin
      applyStimulus(0, 300, 1'b0, 1'b0);
      applyStimulus(1, 0, 1'b0, 1'b0);
      applyStimulus(2, 0, 1'b0, 1'b0);
      applyStimulus(3, 0, 1'b1, 1'b0);
    end
    drain();
    checkOutput("t3First", 32'(firstCh0), 32'(12'd1));
    checkOutput("t3Settle", 32'(lastOut[0]), 32'(12'd299));
    checkOutput("t3Mono", 32'(monoErr), 32'(0));
    checkOutput("t3Others", 32'(otherNonZero), 32'(0));

    // Test 4: downstream stall for five cycles
    mReady = 1'b0;
    applyStimulus(0, 300, 1'b0, 1'b0);
    @(posedge aclk); #1;
    sUser = 2'd2;
    sData = 12'd0;
    repeat (5) begin
      @(negedge aclk);
      checkOutput("t4Ready", 32'(sReady), 32'(0));
      checkOutput("t4Valid", 32'(mValid), 32'(1));
      checkOutput("t4Hold", 32'(mData), 32'(12'd299));
    end
    @(posedge aclk); #1 mReady = 1'b1;
    @(negedge aclk);
    checkOutput("t4Resume", 32'(sReady), 32'(1));
    drain();
    checkOutput("t4Ch2", 32'(lastOut[2]), 32'(0));

    // Test 5: clear coinciding with an accept
    applyStimulus(0, 300, 1'b0, 1'b1);
    drain();
    checkOutput("t5PreClear", 32'(lastOut[0]), 32'(12'd299));
    applyStimulus(0, 300, 1'b0, 1'b0);
    drain();
    checkOutput("t5PostClear", 32'(lastOut[0]), 32'(12'd1));

    // Test 6: reset in the middle of a stream
    for (int i = 0; i < 20; i++) applyStimulus(0, 300, 1'b0, 1'b0);
    @(posedge aclk); #1;
    sValid = 1'b0;
    resetn = 1'b0;
    #1;
    checkOutput("t6RstValid", 32'(mValid), 32'(0));
    repeat (2) @(posedge aclk);
    #1 resetn = 1'b1;
    applyStimulus(0, 300, 1'b0, 1'b0);
    drain();
    checkOutput("t6First", 32'(lastOut[0]), 32'(12'd1));

    nTests++;
    assert (sbQ.size() == 0) else begin
      nFail++;
      $error("[TB] FAIL sbLeftover observed=%0d expected=0", sbQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
